// File: rtl/vga_timing_ctrl_if.sv
// Signal bundle between the VGA timing controller, its panel/pixel source and the DAC side.
// master = timing controller, slave = panel stage plus display consumer.
interface vga_timing_ctrl_if;
   logic [23:0] pix_data;
   logic [9:0]  pos_x;
   logic [9:0]  pos_y;
   logic        frame_start;
   logic        hsync;
   logic        vsync;
   logic        video_on;
   logic [23:0] rgb_out;

   modport master (
      input  pix_data,
      output pos_x, pos_y, frame_start, hsync, vsync, video_on, rgb_out
   );

   modport slave (
      output pix_data,
      input  pos_x, pos_y, frame_start, hsync, vsync, video_on, rgb_out
   );
endinterface

// File: rtl/vga_timing_ctrl.sv
// Free-running VGA raster timing: pixel request coordinates, delayed syncs/enable and the
// registered output colour, all aligned PIPE_DELAY clocks after the request.
module vga_timing_ctrl #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned H_FRONT    = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BACK     = 48,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned V_FRONT    = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BACK     = 33,
   parameter int unsigned PIPE_DELAY = 2
) (
   input  logic             vga_clk,
   input  logic             rst_n,
   vga_timing_ctrl_if.master bus
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

   localparam logic [HW-1:0] HActEnd  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HSyncBeg = HW'(H_ACTIVE + H_FRONT);
   localparam logic [HW-1:0] HSyncEnd = HW'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [HW-1:0] HMax     = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] VActEnd  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VSyncBeg = VW'(V_ACTIVE + V_FRONT);
   localparam logic [VW-1:0] VSyncEnd = VW'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [VW-1:0] VMax     = VW'(V_TOTAL - 1);

   logic [HW-1:0]         r_h_cnt;
   logic [VW-1:0]         r_v_cnt;
   logic [PIPE_DELAY-1:0] r_hs_pipe;
   logic [PIPE_DELAY-1:0] r_vs_pipe;
   logic [PIPE_DELAY-1:0] r_de_pipe;
   logic [23:0]           r_rgb;

   logic                  w_h_act;
   logic                  w_v_act;
   logic                  w_de_req;
   logic                  w_hs_req;
   logic                  w_vs_req;
   logic [PIPE_DELAY:0]   w_hs_chain;
   logic [PIPE_DELAY:0]   w_vs_chain;
   logic [PIPE_DELAY:0]   w_de_chain;

   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (r_h_cnt == HMax) begin
         r_h_cnt <= '0;
         r_v_cnt <= (r_v_cnt == VMax) ? '0 : r_v_cnt + VW'(1);
      end else begin
         r_h_cnt <= r_h_cnt + HW'(1);
      end
   end

   always_comb begin
      w_h_act  = (r_h_cnt < HActEnd);
      w_v_act  = (r_v_cnt < VActEnd);
      w_de_req = w_h_act && w_v_act;
      w_hs_req = !((r_h_cnt >= HSyncBeg) && (r_h_cnt < HSyncEnd));
      w_vs_req = !((r_v_cnt >= VSyncBeg) && (r_v_cnt < VSyncEnd));
   end

   // Bit 0 of each chain is the live request, bit k the copy k clocks old.
   assign w_hs_chain = {r_hs_pipe, w_hs_req};
   assign w_vs_chain = {r_vs_pipe, w_vs_req};
   assign w_de_chain = {r_de_pipe, w_de_req};

   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hs_pipe <= '1;
         r_vs_pipe <= '1;
         r_de_pipe <= '0;
         r_rgb     <= '0;
      end else begin
         r_hs_pipe <= w_hs_chain[PIPE_DELAY-1:0];
         r_vs_pipe <= w_vs_chain[PIPE_DELAY-1:0];
         r_de_pipe <= w_de_chain[PIPE_DELAY-1:0];
         // Panel answers PIPE_DELAY-1 clocks after request; gate with the enable of that age.
         r_rgb     <= w_de_chain[PIPE_DELAY-1] ? bus.pix_data : 24'h000000;
      end
   end

   assign bus.pos_x       = w_h_act ? 10'(r_h_cnt) : 10'd0;
   assign bus.pos_y       = w_v_act ? 10'(r_v_cnt) : 10'd0;
   assign bus.frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
   assign bus.hsync       = r_hs_pipe[PIPE_DELAY-1];
   assign bus.vsync       = r_vs_pipe[PIPE_DELAY-1];
   assign bus.video_on    = r_de_pipe[PIPE_DELAY-1];
   assign bus.rgb_out     = r_rgb;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl on a shrunken raster (90 x 50 clocks per frame) so that
// several frames fit in a short run; all expectations are derived from the bench constants.
module tb_vga_timing_ctrl;
   localparam int unsigned HA = 64, HF = 8, HS = 12, HB = 6;
   localparam int unsigned VA = 40, VF = 3, VS = 2, VB = 5;
   localparam int unsigned PD = 2;
   localparam int unsigned HT = HA + HF + HS + HB;
   localparam int unsigned VT = VA + VF + VS + VB;
   localparam int unsigned FT = HT * VT;

   logic vga_clk = 1'b0;
   logic rst_n   = 1'b0;
   int   n_total = 0;
   int   n_bad   = 0;
   int   k       = 0;

   vga_timing_ctrl_if bus ();

   vga_timing_ctrl #(
      .H_ACTIVE  (HA),
      .H_FRONT   (HF),
      .H_SYNC    (HS),
      .H_BACK    (HB),
      .V_ACTIVE  (VA),
      .V_FRONT   (VF),
      .V_SYNC    (VS),
      .V_BACK    (VB),
      .PIPE_DELAY(PD)
   ) u_dut (
      .vga_clk(vga_clk),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   always #5 vga_clk = ~vga_clk;

   // Stub panel: colour encodes the requested coordinate, returned one clock late.
   always @(posedge vga_clk) bus.pix_data <= {bus.pos_y, bus.pos_x, 4'h0};

   typedef struct {
      int unsigned k;
      logic [9:0]  px;
      logic [9:0]  py;
      logic        fs;
      logic        hs;
      logic        vs;
      logic        de;
      logic [23:0] rgb;
   } vec_t;

   vec_t tbl[22];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge vga_clk);
      #1;
      k++;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pos_x"}, 32'(bus.pos_x), 0);
      check({tag, "_pos_y"}, 32'(bus.pos_y), 0);
      check({tag, "_frame_start"}, 32'(bus.frame_start), 1);
      check({tag, "_hsync"}, 32'(bus.hsync), 1);
      check({tag, "_vsync"}, 32'(bus.vsync), 1);
      check({tag, "_video_on"}, 32'(bus.video_on), 0);
      check({tag, "_rgb_out"}, 32'(bus.rgb_out), 0);
   endtask

   // Window scan of a sync line: first low offset and total low clocks.
   task automatic measure_low(input bit is_v, input int unsigned win,
                              output int unsigned t_fall, output int unsigned n_low);
      logic s;
      t_fall = win;
      n_low  = 0;
      for (int i = 0; i < int'(win); i++) begin
         s = is_v ? bus.vsync : bus.hsync;
         if (!s && t_fall == win) t_fall = i;
         if (!s) n_low++;
         step();
      end
   endtask

   initial begin
      int unsigned t_fall, n_low, gap, n_de, n_err;
      int unsigned h, v, rh, rv, r;
      logic        e_de, e_hs, e_vs;
      logic [23:0] e_rgb;
      logic [9:0]  e_px, e_py;

      //            k     px  py fs hs vs de rgb
      tbl[0]  = '{0,    0,  0, 1, 1, 1, 0, 24'h0};
      tbl[1]  = '{1,    1,  0, 0, 1, 1, 0, 24'h0};
      tbl[2]  = '{2,    2,  0, 0, 1, 1, 1, 24'h0};
      tbl[3]  = '{3,    3,  0, 0, 1, 1, 1, 24'h10};
      tbl[4]  = '{65,   0,  0, 0, 1, 1, 1, 24'h3F0};
      tbl[5]  = '{66,   0,  0, 0, 1, 1, 0, 24'h0};
      tbl[6]  = '{73,   0,  0, 0, 1, 1, 0, 24'h0};
      tbl[7]  = '{74,   0,  0, 0, 0, 1, 0, 24'h0};
      tbl[8]  = '{85,   0,  0, 0, 0, 1, 0, 24'h0};
      tbl[9]  = '{86,   0,  0, 0, 1, 1, 0, 24'h0};
      tbl[10] = '{90,   0,  1, 0, 1, 1, 0, 24'h0};
      tbl[11] = '{92,   2,  1, 0, 1, 1, 1, 24'h4000};
      tbl[12] = '{95,   5,  1, 0, 1, 1, 1, 24'h4030};
      tbl[13] = '{3575, 0, 39, 0, 1, 1, 1, 24'h9C3F0};
      tbl[14] = '{3871, 1,  0, 0, 1, 1, 0, 24'h0};
      tbl[15] = '{3872, 2,  0, 0, 1, 0, 0, 24'h0};
      tbl[16] = '{4051, 1,  0, 0, 1, 0, 0, 24'h0};
      tbl[17] = '{4052, 2,  0, 0, 1, 1, 0, 24'h0};
      tbl[18] = '{4499, 0,  0, 0, 1, 1, 0, 24'h0};
      tbl[19] = '{4500, 0,  0, 1, 1, 1, 0, 24'h0};
      tbl[20] = '{4501, 1,  0, 0, 1, 1, 0, 24'h0};
      tbl[21] = '{4503, 3,  0, 0, 1, 1, 1, 24'h10};

      // Reset values while held in reset across clock edges.
      repeat (3) step();
      check_reset_outputs("in_reset");

      @(negedge vga_clk);
      rst_n = 1'b1;
      #1;
      k = 0;

      foreach (tbl[i]) begin
         while (k < int'(tbl[i].k)) step();
         check($sformatf("vec%0d_pos_x", i), 32'(bus.pos_x), 32'(tbl[i].px));
         check($sformatf("vec%0d_pos_y", i), 32'(bus.pos_y), 32'(tbl[i].py));
         check($sformatf("vec%0d_frame_start", i), 32'(bus.frame_start), 32'(tbl[i].fs));
         check($sformatf("vec%0d_hsync", i), 32'(bus.hsync), 32'(tbl[i].hs));
         check($sformatf("vec%0d_vsync", i), 32'(bus.vsync), 32'(tbl[i].vs));
         check($sformatf("vec%0d_video_on", i), 32'(bus.video_on), 32'(tbl[i].de));
         check($sformatf("vec%0d_rgb_out", i), 32'(bus.rgb_out), 32'(tbl[i].rgb));
      end

      // hsync over line 1 of frame 2.
      while (k < int'(FT + HT)) step();
      measure_low(1'b0, HT, t_fall, n_low);
      check("hsync_fall_offset", t_fall, HA + HF + PD);
      check("hsync_low_clocks", n_low, HS);

      // vsync around the first sync line of frame 2.
      while (k < int'(FT + (VA + VF) * HT)) step();
      measure_low(1'b1, 3 * HT, t_fall, n_low);
      check("vsync_fall_offset", t_fall, PD);
      check("vsync_low_clocks", n_low, VS * HT);

      // Align to the next frame_start, bounded.
      gap = 0;
      while (!bus.frame_start && gap < FT + 10) begin
         step();
         gap++;
      end
      check("frame_start_found", 32'(bus.frame_start), 1);

      // Full frame against a raster model derived from the timing constants.
      n_de  = 0;
      n_err = 0;
      gap   = 0;
      do begin
         h  = gap % HT;
         v  = (gap / HT) % VT;
         r  = (gap >= PD) ? gap - PD : gap + FT - PD;
         rh = r % HT;
         rv = (r / HT) % VT;
         e_px  = (h < HA) ? 10'(h) : 10'd0;
         e_py  = (v < VA) ? 10'(v) : 10'd0;
         e_de  = (rh < HA) && (rv < VA);
         e_hs  = !((rh >= HA + HF) && (rh < HA + HF + HS));
         e_vs  = !((rv >= VA + VF) && (rv < VA + VF + VS));
         e_rgb = e_de ? {10'(rv), 10'(rh), 4'h0} : 24'h0;
         if (bus.pos_x !== e_px || bus.pos_y !== e_py || bus.hsync !== e_hs ||
             bus.vsync !== e_vs || bus.video_on !== e_de || bus.rgb_out !== e_rgb)
            n_err++;
         if (bus.video_on === 1'b1) n_de++;
         step();
         gap++;
      end while (!bus.frame_start && gap < FT + 10);
      check("frame_model_errors", n_err, 0);
      check("frame_period", gap, FT);
      check("video_on_per_frame", n_de, HA * VA);

      // Mid-frame asynchronous reset at h=30, v=20 (an active, nonzero pixel).
      for (int i = 0; i < int'(20 * HT + 30); i++) step();
      check("pre_reset_video_on", 32'(bus.video_on), 1);
      check("pre_reset_pos_x", 32'(bus.pos_x), 30);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      repeat (2) step();
      @(negedge vga_clk);
      rst_n = 1'b1;
      #1;
      check("release_frame_start", 32'(bus.frame_start), 1);
      gap = 0;
      do begin
         step();
         gap++;
      end while (!bus.frame_start && gap < FT + 10);
      check("post_reset_frame_period", gap, FT);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
